// File: rtl/pcie_rx_tlp_parser_if.sv
// Receive stream from the PCIe core into the TLP parser.
// 64-bit beats, DW0 in [31:0] and DW1 in [63:32]; no back-pressure.
interface pcie_rx_tlp_parser_if;
  logic        tvalid;
  logic        tlast;
  logic [63:0] tdata;

  modport master (output tvalid, tlast, tdata);
  modport slave  (input  tvalid, tlast, tdata);
endinterface

// File: rtl/pcie_rx_tlp_parser.sv
// PCIe receive TLP parser: decodes MWr32/64, MRd32/64 (1-2 DW) and CplD from
// the core's 64-bit stream, emitting byte-reversed qword payload with a write
// address or completion slot, plus read-request info for the completer.
// Optional feature macro: PCIE_RX_ERR_COUNT_EN (saturating unsupported-TLP count).
module pcie_rx_tlp_parser #(
  parameter int ADDR_WIDTH = 13,
  parameter int IDX_WIDTH  = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  pcie_rx_tlp_parser_if.slave    rx,
  output logic                   write_valid,
  output logic                   write_half,
  output logic                   completion_valid,
  output logic [IDX_WIDTH-1:0]   completion_index,
  output logic [7:0]             completion_tag,
  output logic [63:0]            data,
  output logic [ADDR_WIDTH-1:0]  address,
  output logic                   read_valid,
  output logic                   read_len2,
  output logic [31:0]            rr_rc_dw2,
  output logic                   unsupported,
  output logic [15:0]            err_count
);

  typedef enum logic [1:0] {HDR01, HDR23, PAYLOAD} state_e;
  typedef enum logic [2:0] {K_MWR32, K_MWR64, K_MRD32, K_MRD64, K_CPLD, K_OTHER} kind_e;

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  function automatic kind_e decode(input logic [6:0] fmt_type);
    case (fmt_type)
      7'h40:   return K_MWR32;
      7'h60:   return K_MWR64;
      7'h00:   return K_MRD32;
      7'h20:   return K_MRD64;
      7'h4A:   return K_CPLD;
      default: return K_OTHER;
    endcase
  endfunction

  state_e                 state_q, state_d;
  logic                   in_valid_q, in_valid_d, in_last_q, in_last_d;
  logic [63:0]            in_data_q, in_data_d;
  kind_e                  kind_q, kind_d;
  logic [9:0]             len_q, len_d;
  logic                   unsup_q, unsup_d;
  logic [15:0]            req_id_q, req_id_d;
  logic [7:0]             tag_q, tag_d, ctag_q, ctag_d;
  logic [IDX_WIDTH-1:0]   bc_idx_q, bc_idx_d, cidx_q, cidx_d;
  logic [31:0]            hold_q, hold_d, flush_dw_q, flush_dw_d;
  logic [ADDR_WIDTH-1:0]  waddr_q, waddr_d;
  logic                   flush_q, flush_d, flush_cpl_q, flush_cpl_d;
  logic                   write_valid_q, write_valid_d, write_half_q, write_half_d;
  logic                   completion_valid_q, completion_valid_d;
  logic [IDX_WIDTH-1:0]   completion_index_q, completion_index_d;
  logic [7:0]             completion_tag_q, completion_tag_d;
  logic [63:0]            data_q, data_d;
  logic [ADDR_WIDTH-1:0]  address_q, address_d;
  logic                   read_valid_q, read_valid_d, read_len2_q, read_len2_d;
  logic [31:0]            rr_rc_dw2_q, rr_rc_dw2_d;
  logic                   unsupported_q, unsupported_d;

  logic                   emit_en, emit_cpl, emit_half;
  logic [63:0]            emit_data;
  logic [ADDR_WIDTH-1:0]  wbase;
  logic [IDX_WIDTH-1:0]   cbase;
  logic [7:0]             tbase;

  // State register
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) state_q <= HDR01;
    else       state_q <= state_d;
  end

  // Next state: walk header beats, any tlast returns to HDR01; idle cycles hold
  always_comb begin
    state_d = state_q;
    if (in_valid_q) begin
      if (in_last_q) state_d = HDR01;
      else begin
        unique case (state_q)
          HDR01:   state_d = HDR23;
          HDR23:   state_d = PAYLOAD;
          default: state_d = PAYLOAD;
        endcase
      end
    end
  end

  // Output/datapath decode of the registered beat
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latches are inferred.
    in_valid_d = rx.tvalid;
    in_last_d  = rx.tlast;
    in_data_d  = rx.tdata;
    kind_d = kind_q;  len_d = len_q;  unsup_d = unsup_q;
    req_id_d = req_id_q;  tag_d = tag_q;  bc_idx_d = bc_idx_q;
    hold_d = hold_q;  waddr_d = waddr_q;  cidx_d = cidx_q;  ctag_d = ctag_q;
    flush_d = 1'b0;  flush_cpl_d = flush_cpl_q;  flush_dw_d = flush_dw_q;
    write_valid_d = 1'b0;  write_half_d = 1'b0;  completion_valid_d = 1'b0;
    completion_index_d = completion_index_q;  completion_tag_d = completion_tag_q;
    data_d = data_q;  address_d = address_q;
    read_valid_d = 1'b0;  read_len2_d = read_len2_q;  rr_rc_dw2_d = rr_rc_dw2_q;
    unsupported_d = 1'b0;
    emit_en = 1'b0;  emit_cpl = 1'b0;  emit_half = 1'b0;  emit_data = '0;
    wbase = waddr_q;  cbase = cidx_q;  tbase = ctag_q;

    // Odd 3DW tail left over from the previous TLP's last beat; the beat in
    // flight this cycle can only be a header, which emits nothing.
    if (flush_q) begin
      emit_en   = 1'b1;
      emit_cpl  = flush_cpl_q;
      emit_half = 1'b1;
      emit_data = {32'h0, bswap(flush_dw_q)};
    end

    if (in_valid_q) begin
      unique case (state_q)
        HDR01: begin
          kind_d   = decode(in_data_q[30:24]);
          len_d    = in_data_q[9:0];
          unsup_d  = (kind_d == K_OTHER) ||
                     (((kind_d == K_MRD32) || (kind_d == K_MRD64)) &&
                      (in_data_q[9:0] != 10'd1) && (in_data_q[9:0] != 10'd2));
          req_id_d = in_data_q[63:48];
          tag_d    = in_data_q[47:40];
          bc_idx_d = in_data_q[IDX_WIDTH+34:35];
          if (in_last_q && unsup_d) unsupported_d = 1'b1;
        end
        HDR23: begin
          unique case (kind_q)
            K_MWR32, K_CPLD: begin
              if (kind_q == K_MWR32) begin
                wbase   = in_data_q[ADDR_WIDTH+2:3];
                waddr_d = wbase;
              end else begin
                cbase  = {IDX_WIDTH{1'b0}} - bc_idx_q;
                cidx_d = cbase;
                tbase  = in_data_q[15:8];
                ctag_d = tbase;
              end
              // DW3 is the first payload DW: alone if the TLP ends here, else carried.
              if (in_last_q) begin
                emit_en   = 1'b1;
                emit_cpl  = (kind_q == K_CPLD);
                emit_half = 1'b1;
                emit_data = {32'h0, bswap(in_data_q[63:32])};
              end else begin
                hold_d = in_data_q[63:32];
              end
            end
            K_MWR64: begin
              wbase   = in_data_q[ADDR_WIDTH+34:35];
              waddr_d = wbase;
            end
            K_MRD32, K_MRD64: begin
              if (!unsup_q) begin
                read_valid_d = 1'b1;
                read_len2_d  = (len_q == 10'd2);
                rr_rc_dw2_d  = {req_id_q, tag_q, 1'b0,
                                (kind_q == K_MRD32) ? in_data_q[6:3] : in_data_q[38:35],
                                3'b000};
              end
            end
            default: ;
          endcase
          if (in_last_q && unsup_q) unsupported_d = 1'b1;
        end
        default: begin
          unique case (kind_q)
            K_MWR32, K_CPLD: begin
              emit_en   = 1'b1;
              emit_cpl  = (kind_q == K_CPLD);
              emit_data = {bswap(in_data_q[31:0]), bswap(hold_q)};
              if (in_last_q && len_q[0]) begin
                flush_d     = 1'b1;
                flush_cpl_d = (kind_q == K_CPLD);
                flush_dw_d  = in_data_q[63:32];
              end else begin
                hold_d = in_data_q[63:32];
              end
            end
            K_MWR64: begin
              emit_en = 1'b1;
              if (in_last_q && len_q[0]) begin
                emit_half = 1'b1;
                emit_data = {32'h0, bswap(in_data_q[31:0])};
              end else begin
                emit_data = {bswap(in_data_q[63:32]), bswap(in_data_q[31:0])};
              end
            end
            default: ;
          endcase
          if (in_last_q && unsup_q) unsupported_d = 1'b1;
        end
      endcase
    end

    if (emit_en) begin
      data_d = emit_data;
      if (emit_cpl) begin
        completion_valid_d = 1'b1;
        completion_index_d = cbase;
        completion_tag_d   = tbase;
        cidx_d             = cbase + IDX_WIDTH'(1);
      end else begin
        write_valid_d = 1'b1;
        write_half_d  = emit_half;
        address_d     = wbase;
        waddr_d       = wbase + ADDR_WIDTH'(1);
      end
    end
  end

  // Input beat, per-TLP context and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      in_valid_q <= 1'b0;  in_last_q <= 1'b0;  in_data_q <= '0;
      kind_q <= K_OTHER;  len_q <= '0;  unsup_q <= 1'b0;
      req_id_q <= '0;  tag_q <= '0;  bc_idx_q <= '0;
      hold_q <= '0;  waddr_q <= '0;  cidx_q <= '0;  ctag_q <= '0;
      flush_q <= 1'b0;  flush_cpl_q <= 1'b0;  flush_dw_q <= '0;
      write_valid_q <= 1'b0;  write_half_q <= 1'b0;  completion_valid_q <= 1'b0;
      completion_index_q <= '0;  completion_tag_q <= '0;
      data_q <= '0;  address_q <= '0;
      read_valid_q <= 1'b0;  read_len2_q <= 1'b0;  rr_rc_dw2_q <= '0;
      unsupported_q <= 1'b0;
    end else begin
      in_valid_q <= in_valid_d;  in_last_q <= in_last_d;  in_data_q <= in_data_d;
      kind_q <= kind_d;  len_q <= len_d;  unsup_q <= unsup_d;
      req_id_q <= req_id_d;  tag_q <= tag_d;  bc_idx_q <= bc_idx_d;
      hold_q <= hold_d;  waddr_q <= waddr_d;  cidx_q <= cidx_d;  ctag_q <= ctag_d;
      flush_q <= flush_d;  flush_cpl_q <= flush_cpl_d;  flush_dw_q <= flush_dw_d;
      write_valid_q <= write_valid_d;  write_half_q <= write_half_d;
      completion_valid_q <= completion_valid_d;
      completion_index_q <= completion_index_d;  completion_tag_q <= completion_tag_d;
      data_q <= data_d;  address_q <= address_d;
      read_valid_q <= read_valid_d;  read_len2_q <= read_len2_d;  rr_rc_dw2_q <= rr_rc_dw2_d;
      unsupported_q <= unsupported_d;
    end
  end

  assign write_valid      = write_valid_q;
  assign write_half       = write_half_q;
  assign completion_valid = completion_valid_q;
  assign completion_index = completion_index_q;
  assign completion_tag   = completion_tag_q;
  assign data             = data_q;
  assign address          = address_q;
  assign read_valid       = read_valid_q;
  assign read_len2        = read_len2_q;
  assign rr_rc_dw2        = rr_rc_dw2_q;
  assign unsupported      = unsupported_q;

`ifdef PCIE_RX_ERR_COUNT_EN
  logic [15:0] err_count_q, err_count_d;

  // Saturating count of unsupported TLPs, aligned with the unsupported pulse
  always_comb begin
    err_count_d = err_count_q;
    if (unsupported_d && (err_count_q != 16'hFFFF)) err_count_d = err_count_q + 16'd1;
  end

  // Error counter register
  always_ff @(posedge clock) begin
    if (reset) err_count_q <= '0;
    else       err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`else
  assign err_count = 16'd0;
`endif

endmodule

// File: tb/tb_pcie_rx_tlp_parser.sv
// Directed self-checking bench for pcie_rx_tlp_parser.
module tb_pcie_rx_tlp_parser;
  localparam int AW = 13;
  localparam int IW = 6;
`ifdef PCIE_RX_ERR_COUNT_EN
  localparam logic [15:0] EXP_ERR = 16'd3;
`else
  localparam logic [15:0] EXP_ERR = 16'd0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pcie_rx_tlp_parser_if bus ();

  logic           write_valid, write_half, completion_valid;
  logic [IW-1:0]  completion_index;
  logic [7:0]     completion_tag;
  logic [63:0]    data;
  logic [AW-1:0]  address;
  logic           read_valid, read_len2, unsupported;
  logic [31:0]    rr_rc_dw2;
  logic [15:0]    err_count;

  pcie_rx_tlp_parser #(.ADDR_WIDTH(AW), .IDX_WIDTH(IW)) dut (
    .clock(clock), .reset(reset), .rx(bus.slave),
    .write_valid(write_valid), .write_half(write_half),
    .completion_valid(completion_valid), .completion_index(completion_index),
    .completion_tag(completion_tag), .data(data), .address(address),
    .read_valid(read_valid), .read_len2(read_len2), .rr_rc_dw2(rr_rc_dw2),
    .unsupported(unsupported), .err_count(err_count)
  );

  typedef struct { logic [AW-1:0] addr; logic half; logic [63:0] data; int cyc; } wr_ev_t;
  typedef struct { logic [IW-1:0] idx; logic [7:0] tag; logic [63:0] data; } cpl_ev_t;
  typedef struct { logic len2; logic [31:0] dw2; int cyc; } rd_ev_t;

  wr_ev_t  wr_q[$];
  cpl_ev_t cpl_q[$];
  rd_ev_t  rd_q[$];
  int      unsup_n = 0;
  int      cyc = 0;
  int      last_drive_cyc = 0;
  int      tests_run = 0;
  int      tests_failed = 0;

  // Cycle counter used to measure output latency
  always @(posedge clock) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge
  always @(negedge clock) begin
    if (write_valid)      wr_q.push_back('{address, write_half, data, cyc});
    if (completion_valid) cpl_q.push_back('{completion_index, completion_tag, data});
    if (read_valid)       rd_q.push_back('{read_len2, rr_rc_dw2, cyc});
    if (unsupported)      unsup_n++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int k, input logic [AW-1:0] a,
                        input logic h, input logic [63:0] d);
    check({tag, "_present"}, 64'(k < wr_q.size()), 64'd1);
    if (k < wr_q.size()) begin
      check({tag, "_addr"}, 64'(wr_q[k].addr), 64'(a));
      check({tag, "_half"}, 64'(wr_q[k].half), 64'(h));
      check({tag, "_data"}, wr_q[k].data, d);
    end
  endtask

  task automatic beat(input logic last, input logic [63:0] d);
    @(negedge clock);
    bus.tvalid = 1'b1;
    bus.tlast  = last;
    bus.tdata  = d;
    last_drive_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      bus.tvalid = 1'b0;
      bus.tlast  = 1'b0;
      bus.tdata  = '0;
    end
  endtask

  task automatic clear();
    wr_q.delete();
    cpl_q.delete();
    rd_q.delete();
    unsup_n = 0;
  endtask

  initial begin
    int tl;
    bus.tvalid = 1'b0;
    bus.tlast  = 1'b0;
    bus.tdata  = '0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_valids", 64'({write_valid, completion_valid, read_valid, unsupported}), 64'd0);
    check("rst_data", data, 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    reset = 1'b0;
    idle(2);

    // MWr32 addr 0x100, len 4
    clear();
    beat(1'b0, 64'h000000FF_40000004);
    beat(1'b0, 64'h11223344_00000100);
    beat(1'b0, 64'h99AABBCC_55667788);
    beat(1'b1, 64'h00000000_DDEEFF00);
    idle(4);
    check("t1_wr_count", 64'(wr_q.size()), 64'd2);
    chk_wr("t1_q0", 0, 13'h0020, 1'b0, 64'h88776655_44332211);
    chk_wr("t1_q1", 1, 13'h0021, 1'b0, 64'h00FFEEDD_CCBBAA99);
    check("t1_no_cpl", 64'(cpl_q.size()), 64'd0);

    // MWr64 addr 0x1_0000_0018, len 3: trailing half qword
    clear();
    beat(1'b0, 64'h000000FF_60000003);
    beat(1'b0, 64'h00000018_00000001);
    beat(1'b0, 64'h05060708_01020304);
    beat(1'b1, 64'h00000000_0A0B0C0D);
    tl = last_drive_cyc;
    idle(4);
    check("t2_wr_count", 64'(wr_q.size()), 64'd2);
    chk_wr("t2_q0", 0, 13'h0003, 1'b0, 64'h08070605_04030201);
    chk_wr("t2_q1", 1, 13'h0004, 1'b1, 64'h00000000_0D0C0B0A);
    if (wr_q.size() > 1) check("t2_tail_latency", 64'(wr_q[1].cyc - tl), 64'd2);

    // CplD tag 0x5A, byte_count 64, 8 DW, with a tvalid gap
    clear();
    beat(1'b0, 64'h01000040_4A000008);
    beat(1'b0, 64'hA0B0C0D0_ABCD5A00);
    beat(1'b0, 64'hA0B0C0D2_A0B0C0D1);
    idle(2);
    beat(1'b0, 64'hA0B0C0D4_A0B0C0D3);
    beat(1'b0, 64'hA0B0C0D6_A0B0C0D5);
    beat(1'b1, 64'h00000000_A0B0C0D7);
    idle(4);
    check("t3_cpl_count", 64'(cpl_q.size()), 64'd4);
    for (int k = 0; k < 4 && k < cpl_q.size(); k++) begin
      check($sformatf("t3_idx%0d", k), 64'(cpl_q[k].idx), 64'(8'h38 + k));
      check($sformatf("t3_tag%0d", k), 64'(cpl_q[k].tag), 64'h5A);
      check($sformatf("t3_data%0d", k), cpl_q[k].data,
            64'hD1C0B0A0_D0C0B0A0 + 64'(k) * 64'h02000000_02000000);
    end
    check("t3_no_wr", 64'(wr_q.size()), 64'd0);

    // MRd32 len 2, addr 0x48, requester 0xABCD, tag 0x07
    clear();
    beat(1'b0, 64'hABCD07FF_00000002);
    beat(1'b1, 64'h00000000_00000048);
    tl = last_drive_cyc;
    idle(4);
    check("t4_rd_count", 64'(rd_q.size()), 64'd1);
    if (rd_q.size() > 0) begin
      check("t4_len2", 64'(rd_q[0].len2), 64'd1);
      check("t4_dw2", 64'(rd_q[0].dw2), 64'hABCD0748);
      check("t4_latency", 64'(rd_q[0].cyc - tl), 64'd2);
    end
    check("t4_unsup", 64'(unsup_n), 64'd0);

    // Msg, then MWr32 (3DW odd length, address wrap) with gaps, then MRd32 len 1, back-to-back
    clear();
    beat(1'b0, 64'h00000000_34000000);
    beat(1'b1, 64'h00000000_00000000);
    beat(1'b0, 64'h000000FF_40000003);
    idle(2);
    beat(1'b0, 64'h01234567_0000FFF8);
    idle(1);
    beat(1'b1, 64'hCAFEF00D_89ABCDEF);
    beat(1'b0, 64'h123499FF_00000001);
    beat(1'b1, 64'h00000000_000007F8);
    idle(5);
    check("t5_unsup", 64'(unsup_n), 64'd1);
    check("t5_wr_count", 64'(wr_q.size()), 64'd2);
    chk_wr("t5_q0", 0, 13'h1FFF, 1'b0, 64'hEFCDAB89_67452301);
    chk_wr("t5_q1", 1, 13'h0000, 1'b1, 64'h00000000_0DF0FECA);
    check("t5_rd_count", 64'(rd_q.size()), 64'd1);
    if (rd_q.size() > 0) begin
      check("t5_len2", 64'(rd_q[0].len2), 64'd0);
      check("t5_dw2", 64'(rd_q[0].dw2), 64'h12349978);
    end

    // Reset mid-CplD, then three unsupported TLPs
    clear();
    beat(1'b0, 64'h01000040_4A000008);
    beat(1'b0, 64'hA0B0C0D0_ABCD5A00);
    beat(1'b0, 64'hA0B0C0D2_A0B0C0D1);
    @(negedge clock);
    bus.tvalid = 1'b0;
    bus.tlast  = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("t6_rst_tag", 64'(completion_tag), 64'd0);
    check("t6_rst_rr", 64'(rr_rc_dw2), 64'd0);
    check("t6_rst_data", data, 64'd0);
    check("t6_rst_err", 64'(err_count), 64'd0);
    beat(1'b0, 64'h00000000_34000000);
    beat(1'b1, 64'h00000000_00000000);
    beat(1'b0, 64'hABCD07FF_00000004);
    beat(1'b1, 64'h00000000_00000100);
    beat(1'b0, 64'hABCD07FF_20000003);
    beat(1'b1, 64'h00000100_00000000);
    idle(5);
    check("t6_no_cpl", 64'(cpl_q.size()), 64'd0);
    check("t6_no_wr", 64'(wr_q.size()), 64'd0);
    check("t6_no_rd", 64'(rd_q.size()), 64'd0);
    check("t6_unsup", 64'(unsup_n), 64'd3);
    check("t6_err_count", 64'(err_count), 64'(EXP_ERR));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
